pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_sync_edge.sv | 31 +++
 rtl/pwm_capture.sv | 114 +++++++++++
 tb/tb_pwm_capture.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block and the companion PWM generator.
package pwm_pkg;

  localparam int unsigned CNT_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } pwm_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronizes the asynchronous PWM input and flags its rising/falling edges.
module pwm_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      dly  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm};
      dly  <= sync[SYNC_STAGES-1];
    end
  end

  // dly resets low, so a line held high through reset yields one rise on release
  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~dly;
  assign fall  = ~level & dly;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in clk cycles,
// with a stuck-line timeout and counter-saturation discard.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic                 pwm_i,
  input  logic [CNT_WIDTH-1:0] timeout_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic [CNT_WIDTH-1:0] high_o,
  output logic                 valid_o,
  output logic                 stuck_o,
  output logic                 stuck_lvl_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  pwm_state_t           state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic [CNT_WIDTH-1:0] high_q;
  logic                 level, rise, fall;
  logic                 timeout_hit, cnt_sat;
  logic                 cap_high, cap_period, set_stuck, clr_stuck;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .pwm  (pwm_i),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  assign timeout_hit = (timeout_i != '0) && (cnt == timeout_i);
  assign cnt_sat     = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cap_high   = 1'b0;
    cap_period = 1'b0;
    set_stuck  = 1'b0;
    clr_stuck  = 1'b0;
    if (!enable_i) begin
      state_next = IDLE;
      clr_stuck  = 1'b1;
    end else if (state == IDLE) begin
      state_next = WAIT_RISE;
    end else begin
      // Edges take priority over both timeout and saturation
      if (rise || fall) clr_stuck = 1'b1;
      if (rise) begin
        cap_period = (state == MEAS_LOW);
        state_next = MEAS_HIGH;
      end else if (fall) begin
        if (state == MEAS_HIGH) begin
          cap_high   = 1'b1;
          state_next = MEAS_LOW;
        end
      end else begin
        if (timeout_hit) begin
          set_stuck  = 1'b1;
          state_next = WAIT_RISE;
        end
        if (cnt_sat) state_next = WAIT_RISE;
      end
    end
  end

  always_comb begin
    cnt_next = cnt;
    if (!enable_i || state == IDLE) cnt_next = '0;
    else if (rise)                  cnt_next = CNT_WIDTH'(1);
    else if (!cnt_sat)              cnt_next = cnt + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      high_q      <= '0;
      period_o    <= '0;
      high_o      <= '0;
      valid_o     <= 1'b0;
      stuck_o     <= 1'b0;
      stuck_lvl_o <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      valid_o <= cap_period;
      if (cap_high) high_q <= cnt;
      if (cap_period) begin
        period_o <= cnt;
        high_o   <= high_q;
      end
      if (set_stuck) begin
        stuck_o     <= 1'b1;
        stuck_lvl_o <= level;
      end else if (clr_stuck) begin
        stuck_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture against a timestamp-based reference model.
module tb_pwm_capture;

  localparam int unsigned CW  = 8;
  localparam int unsigned S   = 3;
  localparam int          MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          enable_i;
  logic          pwm_i;
  logic [CW-1:0] timeout_i;
  logic [CW-1:0] period_o;
  logic [CW-1:0] high_o;
  logic          valid_o;
  logic          stuck_o;
  logic          stuck_lvl_o;

  pwm_capture #(
    .CNT_WIDTH  (CW),
    .SYNC_STAGES(S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable_i   (enable_i),
    .pwm_i      (pwm_i),
    .timeout_i  (timeout_i),
    .period_o   (period_o),
    .high_o     (high_o),
    .valid_o    (valid_o),
    .stuck_o    (stuck_o),
    .stuck_lvl_o(stuck_lvl_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the line as seen by the block is the raw pwm sample
  // from S edges earlier; the counter is derived from the last rise/arm time.
  int  n = 16;
  bit  smp [0:65535];
  bit  active, have_rise, have_high;
  int  t_zero, high_meas;
  int  exp_period, exp_high;
  bit  exp_valid, exp_stuck, exp_lvl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, want, n);
    end
  endtask

  task automatic model_step();
    bit level, prev, rise, fall;
    int cnt;
    level     = smp[n-S];
    prev      = smp[n-S-1];
    rise      = level && !prev;
    fall      = !level && prev;
    exp_valid = 1'b0;
    if (rst) begin
      for (int k = n - S; k <= n; k++) smp[k] = 1'b0;
      active     = 1'b0;
      exp_period = 0;
      exp_high   = 0;
      exp_stuck  = 1'b0;
      exp_lvl    = 1'b0;
    end else begin
      smp[n] = pwm_i;
      if (!enable_i) begin
        active    = 1'b0;
        exp_stuck = 1'b0;
      end else if (!active) begin
        active    = 1'b1;
        have_rise = 1'b0;
        have_high = 1'b0;
        t_zero    = n;
      end else begin
        cnt = n - t_zero - 1;
        if (cnt > MAX) cnt = MAX;
        if (rise || fall) exp_stuck = 1'b0;
        if (rise) begin
          if (have_high) begin
            exp_period = cnt;
            exp_high   = high_meas;
            exp_valid  = 1'b1;
          end
          have_rise = 1'b1;
          have_high = 1'b0;
          t_zero    = n - 1;
        end else if (fall) begin
          if (have_rise && !have_high) begin
            high_meas = cnt;
            have_high = 1'b1;
          end
        end else begin
          if (timeout_i != 0 && cnt == int'(timeout_i)) begin
            exp_stuck = 1'b1;
            exp_lvl   = level;
            have_rise = 1'b0;
            have_high = 1'b0;
          end
          if (cnt == MAX) begin
            have_rise = 1'b0;
            have_high = 1'b0;
          end
        end
      end
    end
    n++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("period", period_o, exp_period);
    check("high", high_o, exp_high);
    check("valid", valid_o, exp_valid);
    check("stuck", stuck_o, exp_stuck);
    check("stuck_lvl", stuck_lvl_o, exp_lvl);
  endtask

  task automatic hold(input bit lvl, input int cycles);
    pwm_i = lvl;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  initial begin
    rst       = 1'b1;
    enable_i  = 1'b0;
    pwm_i     = 1'b0;
    timeout_i = '0;
    for (int i = 0; i < 3; i++) tick();
    check("reset_valid", valid_o, 0);
    rst = 1'b0;

    // Steady 30/70 waveform
    enable_i  = 1'b1;
    timeout_i = 8'd200;
    wave(30, 70, 5);
    check("p100", period_o, 100);
    check("h30", high_o, 30);

    // Line stuck low long enough to trip the timeout, then recover
    hold(1'b0, 500);
    check("stuck_low", stuck_o, 1);
    wave(10, 10, 3);

    // Enable dropped mid-high, then a 10/10 waveform
    hold(1'b1, 5);
    enable_i = 1'b0;
    hold(1'b1, 5);
    hold(1'b0, 5);
    enable_i = 1'b1;
    wave(10, 10, 4);
    check("p20", period_o, 20);
    check("h10", high_o, 10);

    // Reset while measuring the low phase
    wave(10, 10, 2);
    hold(1'b1, 10);
    hold(1'b0, 6);
    rst = 1'b1;
    tick();
    check("rst_period", period_o, 0);
    check("rst_high", high_o, 0);
    rst = 1'b0;
    wave(10, 10, 3);

    // Minimum duty cycle, then a static line with timeout disabled
    wave(1, 1, 20);
    check("p2", period_o, 2);
    check("h1", high_o, 1);
    timeout_i = '0;
    hold(1'b1, 400);
    check("no_stuck", stuck_o, 0);

    // Random segments
    for (int seg = 0; seg < 40; seg++) begin
      timeout_i = ($urandom_range(0, 3) == 0) ? CW'(0) : CW'($urandom_range(20, 250));
      case ($urandom_range(0, 7))
        0: begin
          enable_i = 1'b0;
          hold(1'($urandom_range(0, 1)), $urandom_range(1, 12));
          enable_i = 1'b1;
        end
        1: begin
          rst = 1'b1;
          hold(1'($urandom_range(0, 1)), $urandom_range(1, 3));
          rst = 1'b0;
        end
        2: hold(1'($urandom_range(0, 1)), $urandom_range(1, 280));
        default: wave($urandom_range(1, 60), $urandom_range(1, 60), $urandom_range(1, 3));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
